// File: rtl/mem_bus_scheduler_pkg.sv
// Shared constants for the memory-bus scheduler: state encoding, master indices
// and default tenure timing.
package mem_bus_pkg;

    localparam int unsigned NREQ = 4;
    localparam int unsigned PTRW = 2;

    localparam int unsigned GRANT_WAIT_DEF = 2;
    localparam int unsigned MAX_TENURE_DEF = 64;
    localparam int unsigned TCNTW_DEF      = 7;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] BUSY  = 2'd2;
    localparam logic [1:0] TURN  = 2'd3;

    localparam int unsigned REQ_DCACHE = 0;
    localparam int unsigned REQ_SYS    = 1;
    localparam int unsigned REQ_ICACHE = 2;
    localparam int unsigned REQ_DMA    = 3;

endpackage

// File: rtl/mem_bus_scheduler_if.sv
// Request/grant/status bundle between the bus masters and the scheduler.
interface mem_bus_scheduler_if #(
    parameter int unsigned NREQ = mem_bus_pkg::NREQ,
    parameter int unsigned PTRW = mem_bus_pkg::PTRW
);
    logic [NREQ-1:0] req;
    logic            bus_busy;
    logic            cfg_fixed_prio;
    logic [NREQ-1:0] grant;
    logic            grant_valid;
    logic [PTRW-1:0] owner;
    logic            bus_idle;
    logic            noshow_err;
    logic            tenure_err;

    modport master (
        output req, bus_busy, cfg_fixed_prio,
        input  grant, grant_valid, owner, bus_idle, noshow_err, tenure_err
    );

    modport slave (
        input  req, bus_busy, cfg_fixed_prio,
        output grant, grant_valid, owner, bus_idle, noshow_err, tenure_err
    );
endinterface

// File: rtl/mem_bus_scheduler_rr_priority_pick.sv
// Combinational rotate + priority encoder: picks the first set request after
// last_ptr (round-robin) or the lowest set index (fixed priority).
module rr_priority_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   last_ptr_i,
    input  logic            fixed_i,
    output logic [PW-1:0]   winner_o,
    output logic            any_o
);
    logic [PW-1:0]   start;
    logic [NREQ-1:0] rot;
    logic [NREQ-1:0] sel;
    logic [NREQ:0]   seen;
    logic [PW-1:0]   idx;

    // NREQ is a power of two, so PW-bit addition wraps modulo NREQ
    assign start   = fixed_i ? '0 : PW'(last_ptr_i + PW'(1));
    assign seen[0] = 1'b0;

    for (genvar i = 0; i < NREQ; i++) begin : g_chain
        assign rot[i]    = req_i[PW'(PW'(i) + start)];
        assign sel[i]    = rot[i] & ~seen[i];
        assign seen[i+1] = seen[i] | rot[i];
    end

    always_comb begin
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel[i]) idx = idx | PW'(i);
        end
    end

    assign winner_o = PW'(idx + start);
    assign any_o    = seen[NREQ];
endmodule

// File: rtl/mem_bus_scheduler.sv
// Central memory-bus scheduler: arbitrates masters, sequences each tenure
// (grant, busy, release, turnaround) and flags no-show / over-long tenures.
module mem_bus_scheduler
    import mem_bus_pkg::*;
#(
    parameter int unsigned GRANT_WAIT = GRANT_WAIT_DEF,
    parameter int unsigned MAX_TENURE = MAX_TENURE_DEF,
    parameter int unsigned TCNTW      = TCNTW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    mem_bus_scheduler_if.slave bus
);
    logic [1:0]       state_q,    state_d;
    logic [TCNTW-1:0] cnt_q,      cnt_d;
    logic [PTRW-1:0]  last_ptr_q, last_ptr_d;
    logic [PTRW-1:0]  owner_q,    owner_d;
    logic [NREQ-1:0]  grant_q,    grant_d;
    logic             gvalid_q,   gvalid_d;
    logic             idle_q,     idle_d;
    logic             noshow_q,   noshow_d;
    logic             tenure_q,   tenure_d;

    logic [PTRW-1:0]  pick_winner;
    logic             pick_any;

    rr_priority_pick #(.NREQ(NREQ), .PW(PTRW)) u_pick (
        .req_i      (bus.req),
        .last_ptr_i (last_ptr_q),
        .fixed_i    (bus.cfg_fixed_prio),
        .winner_o   (pick_winner),
        .any_o      (pick_any)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_ptr_d = last_ptr_q;
        owner_d    = owner_q;
        grant_d    = grant_q;
        noshow_d   = noshow_q;
        tenure_d   = tenure_q;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d    = GRANT;
                    cnt_d      = '0;
                    grant_d    = NREQ'(1) << pick_winner;
                    owner_d    = pick_winner;
                    last_ptr_d = pick_winner;
                end
            end
            GRANT: begin
                if (bus.bus_busy) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                end else if (!bus.req[owner_q]) begin
                    state_d = TURN;
                    grant_d = '0;
                end else if (cnt_q == TCNTW'(GRANT_WAIT - 1)) begin
                    state_d  = TURN;
                    grant_d  = '0;
                    noshow_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + TCNTW'(1);
                end
            end
            BUSY: begin
                if (!bus.bus_busy) begin
                    state_d = TURN;
                    grant_d = '0;
                end else if (cnt_q != TCNTW'(MAX_TENURE)) begin
                    // flag once the tenure exceeds MAX_TENURE busy cycles; grant is kept
                    cnt_d = cnt_q + TCNTW'(1);
                    if (cnt_q == TCNTW'(MAX_TENURE - 1)) tenure_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        gvalid_d = |grant_d;
        idle_d   = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_ptr_q <= PTRW'(NREQ - 1);
            owner_q    <= '0;
            grant_q    <= '0;
            gvalid_q   <= 1'b0;
            idle_q     <= 1'b1;
            noshow_q   <= 1'b0;
            tenure_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_ptr_q <= last_ptr_d;
            owner_q    <= owner_d;
            grant_q    <= grant_d;
            gvalid_q   <= gvalid_d;
            idle_q     <= idle_d;
            noshow_q   <= noshow_d;
            tenure_q   <= tenure_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = gvalid_q;
    assign bus.owner       = owner_q;
    assign bus.bus_idle    = idle_q;
    assign bus.noshow_err  = noshow_q;
    assign bus.tenure_err  = tenure_q;
endmodule
